// File: rtl/regfile_write_scheduler_if.sv
// W-stage retire bus, register-file write port and decode lookup
// for the writeback scheduler.
interface regfile_write_scheduler_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
);
    logic                       w_valid;
    logic                       w_ready;
    logic [3:0]                 w_icode;
    logic                       w_cnd;
    logic [3:0]                 w_rA;
    logic [3:0]                 w_rB;
    logic [DATA_W-1:0]          w_valE;
    logic [DATA_W-1:0]          w_valM;
    logic                       wr_en;
    logic [3:0]                 wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [3:0]                 q_addr;
    logic                       q_hit;
    logic [DATA_W-1:0]          q_data;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output w_valid, w_icode, w_cnd, w_rA, w_rB, w_valE, w_valM,
        output q_addr,
        input  w_ready, wr_en, wr_addr, wr_data, q_hit, q_data, count
    );

    modport slave (
        input  w_valid, w_icode, w_cnd, w_rA, w_rB, w_valE, w_valM,
        input  q_addr,
        output w_ready, wr_en, wr_addr, wr_data, q_hit, q_data, count
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Queues W-stage dstE/dstM writes and drains one per cycle onto the
// register-file write port, with a youngest-first pending-write lookup.
module regfile_write_scheduler #(
    parameter int         DEPTH  = 4,
    parameter int         DATA_W = 64,
    parameter logic [3:0] RSP    = 4'd4,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input logic                      clk,
    input logic                      rst_n,
    regfile_write_scheduler_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]        addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic              accept;
    logic [3:0]        e_addr;
    logic [3:0]        m_addr;
    logic              e_en;
    logic              m_en;
    logic [1:0]        push;
    logic              pop;
    logic [PW-1:0]     m_idx;
    logic [PW-1:0]     rd_idx;
    logic [PW-1:0]     lk_idx;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    assign accept = bus.w_valid && bus.w_ready;

    always_comb begin
        e_addr = RNONE;
        m_addr = RNONE;
        case (bus.w_icode)
            4'h2: if (bus.w_cnd) e_addr = bus.w_rB;
            4'h3,
            4'h6: e_addr = bus.w_rB;
            4'h5: m_addr = bus.w_rA;
            4'h8,
            4'h9,
            4'hA: e_addr = RSP;
            4'hB: begin
                e_addr = RSP;
                m_addr = bus.w_rA;
            end
            default: ;
        endcase
    end

    assign e_en   = accept && (e_addr != RNONE);
    assign m_en   = accept && (m_addr != RNONE);
    assign push   = {1'b0, e_en} + {1'b0, m_en};
    assign pop    = (count != '0);
    assign m_idx  = e_en ? tail + PW'(1) : tail;
    // When idle, keep presenting the entry that was drained last
    assign rd_idx = pop ? head : head - PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (e_en) begin
                addr_q[tail] <= e_addr;
                data_q[tail] <= bus.w_valE;
            end
            if (m_en) begin
                addr_q[m_idx] <= m_addr;
                data_q[m_idx] <= bus.w_valM;
            end
            tail  <= tail + PW'(push);
            head  <= head + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Walk oldest to youngest so the youngest match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        lk_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head + PW'(i);
            if ((CW'(i) < count) &&
                (addr_q[lk_idx] == bus.q_addr) &&
                (bus.q_addr != RNONE)) begin
                hit      = 1'b1;
                hit_data = data_q[lk_idx];
            end
        end
    end

    assign bus.w_ready = (count <= CW'(DEPTH - 2));
    assign bus.wr_en   = pop;
    assign bus.wr_addr = addr_q[rd_idx];
    assign bus.wr_data = data_q[rd_idx];
    assign bus.q_hit   = hit;
    assign bus.q_data  = hit_data;
    assign bus.count   = count;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: expected writes are
// queued at acceptance and matched against the drained write port.
module tb_regfile_write_scheduler;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  sb[$];
    wr_t  cur;
    logic cur_v = 1'b0;
    logic force_v = 1'b0;
    logic [3:0] force_addr = 4'd0;

    regfile_write_scheduler_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    regfile_write_scheduler #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .RSP(4'd4), .RNONE(4'hF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void add_wr(input logic [3:0] a, input logic [63:0] d);
        wr_t w;
        if (a == 4'hF) return;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endfunction

    function automatic void model(input logic [3:0] ic, input logic c,
                                  input logic [3:0] ra, input logic [3:0] rb,
                                  input logic [63:0] ve, input logic [63:0] vm);
        case (ic)
            4'h2: if (c) add_wr(rb, ve);
            4'h3, 4'h6: add_wr(rb, ve);
            4'h5: add_wr(ra, vm);
            4'h8, 4'h9, 4'hA: add_wr(4'd4, ve);
            4'hB: begin
                add_wr(4'd4, ve);
                add_wr(ra, vm);
            end
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [3:0] ic, input logic c,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm,
                         output int stalls);
        stalls = 0;
        bus.w_icode = ic;
        bus.w_cnd   = c;
        bus.w_rA    = ra;
        bus.w_rB    = rb;
        bus.w_valE  = ve;
        bus.w_valM  = vm;
        bus.w_valid = 1'b1;
        while (bus.w_ready !== 1'b1 && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 50) begin
            check("ready_timeout", 64'd0, 64'd1);
        end else begin
            model(ic, c, ra, rb, ve, vm);
            @(negedge clk);
        end
        bus.w_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.count != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < 100), 64'd1);
    endtask

    always @(posedge clk) begin
        wr_t e;
        logic        exp_hit;
        logic [63:0] exp_data;
        #1;
        cur_v = 1'b0;
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_write", {60'd0, bus.wr_addr}, 64'hF0F0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {60'd0, bus.wr_addr}, {60'd0, e.addr});
                check("wr_data", bus.wr_data, e.data);
                cur   = e;
                cur_v = 1'b1;
            end
        end
        check("count_max", 64'(bus.count <= DEPTH), 64'd1);
        check("w_ready", {63'd0, bus.w_ready}, 64'(bus.count <= DEPTH - 2));
        #2;
        bus.q_addr = force_v ? force_addr : 4'($urandom_range(0, 15));
        #1;
        exp_hit  = 1'b0;
        exp_data = 64'd0;
        if (cur_v && cur.addr == bus.q_addr) begin
            exp_hit  = 1'b1;
            exp_data = cur.data;
        end
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].addr == bus.q_addr) begin
                exp_hit  = 1'b1;
                exp_data = sb[i].data;
            end
        end
        check("q_hit", {63'd0, bus.q_hit}, {63'd0, exp_hit});
        check("q_data", bus.q_data, exp_data);
    end

    initial begin
        int st;
        int total;
        rst_n       = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_icode = 4'h3;
        bus.w_cnd   = 1'b0;
        bus.w_rA    = 4'hF;
        bus.w_rB    = 4'd2;
        bus.w_valE  = 64'h99;
        bus.w_valM  = 64'd0;
        bus.q_addr  = 4'd0;

        repeat (2) @(negedge clk);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
        check("rst_w_ready", {63'd0, bus.w_ready}, 64'd1);
        check("rst_wr_addr", {60'd0, bus.wr_addr}, 64'd0);
        check("rst_wr_data", bus.wr_data, 64'd0);
        rst_n       = 1'b1;
        bus.w_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_count", 64'(bus.count), 64'd0);

        issue(4'h3, 1'b0, 4'hF, 4'd2, 64'h55, 64'd0, st);
        check("single_count", 64'(bus.count), 64'd1);
        check("single_wr_en", {63'd0, bus.wr_en}, 64'd1);
        @(negedge clk);
        check("single_done_count", 64'(bus.count), 64'd0);
        check("single_done_wr_en", {63'd0, bus.wr_en}, 64'd0);

        force_v    = 1'b1;
        force_addr = 4'd4;
        issue(4'hB, 1'b0, 4'd4, 4'hF, 64'h100, 64'h1234, st);
        check("popq_q_hit", {63'd0, bus.q_hit}, 64'd1);
        check("popq_q_data", bus.q_data, 64'h1234);
        @(negedge clk);
        check("popq_second_wr_en", {63'd0, bus.wr_en}, 64'd1);
        @(negedge clk);
        check("popq_done_count", 64'(bus.count), 64'd0);
        force_v = 1'b0;

        issue(4'h2, 1'b0, 4'hF, 4'd3, 64'd7, 64'd0, st);
        check("cmov_nt_count", 64'(bus.count), 64'd0);
        check("cmov_nt_wr_en", {63'd0, bus.wr_en}, 64'd0);
        issue(4'h2, 1'b1, 4'hF, 4'd3, 64'd7, 64'd0, st);
        check("cmov_t_count", 64'(bus.count), 64'd1);
        wait_idle();

        total = 0;
        for (int i = 0; i < 8; i++) begin
            issue(4'h6, 1'b0, 4'hF, 4'(i), 64'(32'hA000 + i), 64'd0, st);
            total += st;
        end
        check("sustained_stalls", 64'(total), 64'd0);
        wait_idle();

        total = 0;
        for (int i = 0; i < 4; i++) begin
            issue(4'hB, 1'b0, 4'(i), 4'hF, 64'(32'hE00 + i),
                  64'(32'hD00 + i), st);
            total += st;
        end
        check("bp_stalled", 64'(total > 0), 64'd1);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom}, st);
        end
        wait_idle();
        check("sb_empty", 64'(sb.size()), 64'd0);

        issue(4'hB, 1'b0, 4'd1, 4'hF, 64'h111, 64'h222, st);
        issue(4'hB, 1'b0, 4'd2, 4'hF, 64'h333, 64'h444, st);
        check("mid_count", 64'(bus.count), 64'd3);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        sb.delete();
        @(negedge clk);
        check("mid_rst_count", 64'(bus.count), 64'd0);
        check("mid_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_rst_quiet", 64'(bus.count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
